// File: rtl/fc_serial_layer_if.sv
// fc_serial_layer_if: layer start/done handshake plus activation/weight/bias read ports and result write port
interface fc_serial_layer_if #(
    parameter int N_IN  = 128,
    parameter int N_OUT = 10
) ();
    localparam int AW = $clog2(N_IN);
    localparam int WW = $clog2(N_IN * N_OUT);
    localparam int OW = $clog2(N_OUT);
    logic                 start_i;
    logic                 done_o;
    logic                 busy_o;
    logic [AW-1:0]        act_addr_o;
    logic signed [31:0]   act_data_i;
    logic [WW-1:0]        w_addr_o;
    logic signed [7:0]    w_data_i;
    logic [OW-1:0]        bias_addr_o;
    logic signed [31:0]   bias_data_i;
    logic                 out_we_o;
    logic [OW-1:0]        out_addr_o;
    logic signed [31:0]   out_data_o;
    modport master (
        output start_i, act_data_i, w_data_i, bias_data_i,
        input  done_o, busy_o, act_addr_o, w_addr_o, bias_addr_o, out_we_o, out_addr_o, out_data_o
    );
    modport slave (
        input  start_i, act_data_i, w_data_i, bias_data_i,
        output done_o, busy_o, act_addr_o, w_addr_o, bias_addr_o, out_we_o, out_addr_o, out_data_o
    );
endinterface

// File: rtl/fc_serial_layer.sv
// fc_serial_layer: serial fully-connected layer, one MAC per cycle, one output neuron at a time
module fc_serial_layer #(
    parameter int N_IN  = 128,
    parameter int N_OUT = 10,
    parameter int RELU  = 0,
    parameter int SHIFT = 0
) (
    input logic               clk,
    input logic               reset,
    fc_serial_layer_if.slave  lyr
);
    localparam int AW = $clog2(N_IN);
    localparam int WW = $clog2(N_IN * N_OUT);
    localparam int OW = $clog2(N_OUT);
    localparam logic [AW-1:0] I_LAST = AW'(N_IN - 1);
    localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

    typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      i_q, i_d;
    logic [OW-1:0]      o_q, o_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] prod;
    logic signed [31:0] shifted;
    logic               busy;

    // Data returning this cycle belongs to the address issued one cycle earlier
    assign prod    = lyr.act_data_i * 32'(lyr.w_data_i);
    assign shifted = acc_q >>> SHIFT;
    assign busy    = state_q inside {BIAS, MAC, DRAIN, WRITE};

    assign lyr.busy_o      = busy;
    assign lyr.done_o      = state_q == DONE;
    assign lyr.out_we_o    = state_q == WRITE;
    assign lyr.out_addr_o  = o_q;
    assign lyr.out_data_o  = (RELU != 0 && shifted < 0) ? '0 : shifted;
    assign lyr.act_addr_o  = i_q;
    assign lyr.bias_addr_o = o_q;
    assign lyr.w_addr_o    = WW'(int'(o_q) * N_IN + int'(i_q));

    // Next-state, counter and accumulator update; a dropped start aborts any busy state
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        o_d     = o_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                i_d     = '0;
                o_d     = '0;
                state_d = lyr.start_i ? BIAS : IDLE;
            end
            BIAS: begin
                i_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d   = (i_q == '0) ? lyr.bias_data_i : acc_q + prod;
                i_d     = (i_q == I_LAST) ? i_q : i_q + AW'(1);
                state_d = (i_q == I_LAST) ? DRAIN : MAC;
            end
            DRAIN: begin
                acc_d   = acc_q + prod;
                state_d = WRITE;
            end
            WRITE: begin
                o_d     = (o_q == O_LAST) ? o_q : o_q + OW'(1);
                state_d = (o_q == O_LAST) ? DONE : BIAS;
            end
            DONE: state_d = lyr.start_i ? DONE : IDLE;
            default: state_d = IDLE;
        endcase
        if (busy && !lyr.start_i) begin
            state_d = IDLE;
            i_d     = '0;
            o_d     = '0;
        end
    end

    // State, counter and accumulator registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            o_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            o_q     <= o_d;
            acc_q   <= acc_d;
        end
    end
endmodule

// File: tb/tb_fc_serial_layer.sv
// tb_fc_serial_layer: random and directed checks of two layer configurations against an arithmetic reference model
module tb_fc_serial_layer;
    localparam int NI = 4;
    localparam int NO = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;

    always #5 clk = ~clk;

    fc_serial_layer_if #(.N_IN(NI), .N_OUT(NO)) b0 ();
    fc_serial_layer_if #(.N_IN(NI), .N_OUT(NO)) b1 ();

    assign b0.start_i = start;
    assign b1.start_i = start;

    fc_serial_layer #(.N_IN(NI), .N_OUT(NO), .RELU(0), .SHIFT(0)) dut0 (.clk(clk), .reset(reset), .lyr(b0));
    fc_serial_layer #(.N_IN(NI), .N_OUT(NO), .RELU(1), .SHIFT(1)) dut1 (.clk(clk), .reset(reset), .lyr(b1));

    int                act_mem [NI];
    logic signed [7:0] w_mem   [NI*NO];
    int                bias_mem[NO];

    // Synchronous one-cycle-latency read ports for both engines
    always @(posedge clk) begin
        b0.act_data_i  <= act_mem[b0.act_addr_o];
        b0.w_data_i    <= w_mem[b0.w_addr_o];
        b0.bias_data_i <= bias_mem[b0.bias_addr_o];
        b1.act_data_i  <= act_mem[b1.act_addr_o];
        b1.w_data_i    <= w_mem[b1.w_addr_o];
        b1.bias_data_i <= bias_mem[b1.bias_addr_o];
    end

    logic [31:0] wa0[$], wd0[$], wa1[$], wd1[$];
    int viol = 0;
    bit done_seen = 0;

    // Write capture and invariant watch, sampled away from the active edge
    always @(negedge clk) begin
        if (b0.out_we_o) begin
            wa0.push_back(32'(b0.out_addr_o));
            wd0.push_back(b0.out_data_o);
        end
        if (b1.out_we_o) begin
            wa1.push_back(32'(b1.out_addr_o));
            wd1.push_back(b1.out_data_o);
        end
        if ((b0.done_o && b0.busy_o) || (b1.done_o && b1.busy_o)) viol++;
        if ((b0.out_we_o && !b0.busy_o) || (b1.out_we_o && !b1.busy_o)) viol++;
        if (b0.done_o) done_seen = 1;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: bias plus dot product in wrapping 32-bit arithmetic, then shift and optional clamp
    function automatic logic [31:0] model(input int o, input int rl, input int sh);
        int acc = bias_mem[o];
        for (int i = 0; i < NI; i++) acc += act_mem[i] * int'(w_mem[o*NI + i]);
        acc = acc >>> sh;
        if (rl != 0 && acc < 0) acc = 0;
        return 32'(acc);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " done"}, 32'(b0.done_o), 0);
        check({tag, " busy"}, 32'(b0.busy_o), 0);
        check({tag, " we"}, 32'(b0.out_we_o), 0);
        check({tag, " act_addr"}, 32'(b0.act_addr_o), 0);
        check({tag, " w_addr"}, 32'(b0.w_addr_o), 0);
        check({tag, " bias_addr"}, 32'(b0.bias_addr_o), 0);
        check({tag, " out_addr"}, 32'(b0.out_addr_o), 0);
        check({tag, " out_data"}, b0.out_data_o, 0);
    endtask

    task automatic check_writes(input string tag);
        check({tag, " nwr0"}, wa0.size(), NO);
        check({tag, " nwr1"}, wa1.size(), NO);
        for (int o = 0; o < NO; o++) begin
            if (o < wa0.size()) begin
                check({tag, " addr0"}, wa0[o], o);
                check({tag, " data0"}, wd0[o], model(o, 0, 0));
            end
            if (o < wa1.size()) begin
                check({tag, " addr1"}, wa1[o], o);
                check({tag, " data1"}, wd1[o], model(o, 1, 1));
            end
        end
    endtask

    task automatic clear_q();
        wa0.delete(); wd0.delete(); wa1.delete(); wd1.delete();
    endtask

    task automatic run(input string tag);
        int n = 0;
        clear_q();
        start = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!b0.done_o && n < 100);
        check({tag, " latency"}, n - 1, NO * (NI + 3));
        check({tag, " busy0 at done"}, 32'(b0.busy_o), 0);
        check({tag, " done1"}, 32'(b1.done_o), 1);
        check({tag, " busy1 at done"}, 32'(b1.busy_o), 0);
        check_writes(tag);
    endtask

    task automatic stop(input string tag);
        start = 1'b0;
        @(negedge clk);
        check({tag, " done fall"}, 32'(b0.done_o), 0);
        @(negedge clk);
    endtask

    task automatic load_basic();
        act_mem  = '{1, 2, 3, 4};
        w_mem    = '{1, 1, 1, 1, -1, 2, 0, 3};
        bias_mem = '{10, -5};
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk);

        load_basic();
        run("basic");
        if (wd0.size() == NO) begin
            check("basic out0", wd0[0], 20);
            check("basic out1", wd0[1], 10);
        end
        if (wd1.size() == NO) begin
            check("shift out0", wd1[0], 10);
            check("shift out1", wd1[1], 5);
        end
        repeat (5) begin
            @(negedge clk);
            check("hold done", 32'(b0.done_o), 1);
        end
        check("hold no extra writes", wa0.size(), NO);
        stop("basic");
        run("rerun");
        stop("rerun");

        bias_mem[1] = -100;
        run("relu");
        if (wd0.size() == NO) check("relu raw out1", wd0[1], 32'hFFFF_FFAB);
        if (wd1.size() == NO) check("relu clamp out1", wd1[1], 0);
        stop("relu");

        act_mem  = '{32'h7FFF_FFFF, 5, 6, 7};
        w_mem    = '{2, 0, 0, 0, 0, 0, 0, 0};
        bias_mem = '{0, 0};
        run("wrap");
        if (wd0.size() == NO) check("wrap out0", wd0[0], 32'hFFFF_FFFE);
        stop("wrap");

        load_basic();
        clear_q();
        done_seen = 0;
        start = 1'b1;
        n = 0;
        while (wa0.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort first write", wa0.size(), 1);
        repeat (2) @(negedge clk);
        check("abort in mac busy", 32'(b0.busy_o), 1);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort busy", 32'(b0.busy_o), 0);
        check("abort writes", wa0.size(), 1);
        check("abort done never", 32'(done_seen), 0);
        run("after abort");
        stop("after abort");

        clear_q();
        start = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle("async reset");
        @(negedge clk);
        reset = 1'b0;
        run("after reset");
        stop("after reset");

        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NI; i++) act_mem[i] = int'($urandom);
            for (int i = 0; i < NI*NO; i++) w_mem[i] = 8'($urandom);
            for (int o = 0; o < NO; o++) bias_mem[o] = int'($urandom);
            run($sformatf("rand%0d", k));
            stop($sformatf("rand%0d", k));
        end

        check("invariants", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
